// File: rtl/sdram_test_pkg.sv
// Shared types for the SDRAM pattern tester and users of async_sdram_ctrl.
package sdram_test_pkg;

  // Data pattern selection, latched when a run starts.
  typedef enum logic [1:0] {
    MODE_ADDR  = 2'd0,
    MODE_WALK  = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_NADDR = 2'd3
  } mode_e;

  // Tester sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: the feedback bit
  // is the XOR of register bits 0, 2, 3 and 5 and enters at bit 15.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  localparam int CMD_ADDR_W = 24;
  localparam int CMD_DATA_W = 16;

  // Command word as pushed into the controller's command FIFO.
  typedef struct packed {
    logic                  we;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/sdram_pattern_gen.sv
// Address and data pattern generator. load restarts the sequence at BASE_ADDR
// with the LFSR seeded; step advances to the next word. addr/data describe the
// current word.
module sdram_pattern_gen
  import sdram_test_pkg::*;
#(
  parameter int                ADDR_W    = 24,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [15:0]       LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              load,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  logic [15:0] walk_q;
  logic [15:0] lfsr_q;
  logic [15:0] pat;

  // Sequence state: address counter wraps naturally, walking one rotates, LFSR shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr   <= BASE_ADDR;
      walk_q <= 16'h0001;
      lfsr_q <= LFSR_SEED;
    end else if (load) begin
      addr   <= BASE_ADDR;
      walk_q <= 16'h0001;
      lfsr_q <= LFSR_SEED;
    end else if (step) begin
      addr   <= addr + 1'b1;
      walk_q <= {walk_q[14:0], walk_q[15]};
      lfsr_q <= {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
    end
  end

  // Pattern select for the current word.
  always_comb begin
    pat = addr[15:0];
    case (mode_e'(mode))
      MODE_ADDR:  pat = addr[15:0];
      MODE_WALK:  pat = walk_q;
      MODE_LFSR:  pat = lfsr_q;
      MODE_NADDR: pat = ~addr[15:0];
    endcase
  end

  assign data = DATA_W'(pat);

endmodule

// File: rtl/sdram_pattern_tester.sv
// Self-checking SDRAM exerciser: writes a pattern block through the command
// FIFO, reads it back with several reads in flight and compares every word.
//
// Handshakes: a command is transferred on a cycle where writer_enq_o=1, which
// is only ever raised while writer_full_i=0; writer_d_o holds the offered
// command and changes only after it was taken. A read word is consumed on a
// cycle where reader_deq_o=1, which is only raised while reader_empty_i=0;
// reader_q_i is valid in that same cycle (first-word-fall-through).
module sdram_pattern_tester
  import sdram_test_pkg::*;
#(
  parameter int                ADDR_W    = 24,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                NUM_WORDS = 1024,
  parameter int                MAX_OUTST = 8,
  parameter logic [15:0]       LFSR_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset_n_i,
  input  logic                     start_i,
  input  logic [1:0]               mode_i,
  input  logic                     loop_i,
  output logic [ADDR_W+DATA_W:0]   writer_d_o,
  output logic                     writer_enq_o,
  input  logic                     writer_full_i,
  input  logic [DATA_W-1:0]        reader_q_i,
  output logic                     reader_deq_o,
  input  logic                     reader_empty_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [15:0]              err_count_o,
  output logic [ADDR_W-1:0]        err_addr_o,
  output logic [DATA_W-1:0]        err_exp_o,
  output logic [DATA_W-1:0]        err_act_o,
  output logic [15:0]              pass_count_o
);

  localparam int CNT_W = $clog2(NUM_WORDS + 1);
  localparam int OST_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] NW      = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(NUM_WORDS - 1);
  localparam logic [OST_W-1:0] OST_MAX = OST_W'(MAX_OUTST);

  state_e            state;
  logic [1:0]        mode_q;
  logic              cmd_valid;
  logic [CNT_W-1:0]  loaded;
  logic [CNT_W-1:0]  issued;
  logic [CNT_W-1:0]  checked;
  logic [OST_W-1:0]  outstanding;

  logic              in_write, in_read, issue_valid;
  logic              phase_start_write, phase_start_read, can_load, mismatch;
  logic [ADDR_W-1:0] wr_addr, is_addr, ck_addr, sel_addr;
  logic [DATA_W-1:0] wr_data, is_data, ck_data, sel_data;

  assign in_write    = (state == ST_WRITE);
  assign in_read     = (state == ST_READ);
  assign issue_valid = cmd_valid & (in_write | (in_read & (outstanding < OST_MAX)));
  assign writer_enq_o = issue_valid & ~writer_full_i;
  assign reader_deq_o = in_read & (checked < NW) & ~reader_empty_i;

  assign phase_start_write = ((state == ST_IDLE) & start_i) | ((state == ST_DONE) & loop_i);
  assign phase_start_read  = in_write & writer_enq_o & (issued == LAST);
  // Refill the command register when it is empty or its command is leaving.
  assign can_load = (in_write | in_read) & (loaded < NW) & (~cmd_valid | writer_enq_o)
                    & ~phase_start_read;

  assign sel_addr = in_write ? wr_addr : is_addr;
  assign sel_data = in_write ? wr_data : is_data;
  assign mismatch = reader_deq_o & (reader_q_i != ck_data);

  sdram_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE_ADDR), .LFSR_SEED(LFSR_SEED))
    u_wr_gen (.clk(clk), .rst_n(reset_n_i), .mode(mode_q), .load(phase_start_write),
              .step(can_load & in_write), .addr(wr_addr), .data(wr_data));

  sdram_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE_ADDR), .LFSR_SEED(LFSR_SEED))
    u_is_gen (.clk(clk), .rst_n(reset_n_i), .mode(mode_q), .load(phase_start_read),
              .step(can_load & in_read), .addr(is_addr), .data(is_data));

  sdram_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(BASE_ADDR), .LFSR_SEED(LFSR_SEED))
    u_ck_gen (.clk(clk), .rst_n(reset_n_i), .mode(mode_q), .load(phase_start_read),
              .step(reader_deq_o), .addr(ck_addr), .data(ck_data));

  // Sequencer, command register, read tracking and status outputs.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state        <= ST_IDLE;
      mode_q       <= '0;
      cmd_valid    <= 1'b0;
      writer_d_o   <= '0;
      loaded       <= '0;
      issued       <= '0;
      checked      <= '0;
      outstanding  <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      error_o      <= 1'b0;
      err_count_o  <= '0;
      err_addr_o   <= '0;
      err_exp_o    <= '0;
      err_act_o    <= '0;
      pass_count_o <= '0;
    end else begin
      done_o <= 1'b0;

      if (can_load) begin
        writer_d_o <= {in_write, sel_addr, in_write ? sel_data : {DATA_W{1'b0}}};
        cmd_valid  <= 1'b1;
        loaded     <= loaded + 1'b1;
      end else if (writer_enq_o) begin
        cmd_valid <= 1'b0;
      end
      if (writer_enq_o) issued <= issued + 1'b1;

      case ({in_read & writer_enq_o, reader_deq_o})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase

      if (reader_deq_o) checked <= checked + 1'b1;

      if (mismatch) begin
        if (err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
        if (!error_o) begin
          error_o    <= 1'b1;
          err_addr_o <= ck_addr;
          err_exp_o  <= ck_data;
          err_act_o  <= reader_q_i;
        end
      end

      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state        <= ST_WRITE;
            mode_q       <= mode_i;
            busy_o       <= 1'b1;
            error_o      <= 1'b0;
            err_count_o  <= '0;
            err_addr_o   <= '0;
            err_exp_o    <= '0;
            err_act_o    <= '0;
            pass_count_o <= '0;
            loaded       <= '0;
            issued       <= '0;
            cmd_valid    <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (phase_start_read) begin
            state       <= ST_READ;
            loaded      <= '0;
            issued      <= '0;
            checked     <= '0;
            outstanding <= '0;
            cmd_valid   <= 1'b0;
          end
        end
        ST_READ: begin
          if (reader_deq_o && (checked == LAST)) begin
            state        <= ST_DONE;
            done_o       <= 1'b1;
            pass_count_o <= pass_count_o + 16'd1;
          end
        end
        ST_DONE: begin
          if (loop_i) begin
            state     <= ST_WRITE;
            loaded    <= '0;
            issued    <= '0;
            cmd_valid <= 1'b0;
          end else begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Directed bench for sdram_pattern_tester with a behavioural command FIFO,
// SDRAM memory and first-word-fall-through read FIFO.
module tb_sdram_pattern_tester;
  import sdram_test_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, start_b = 1'b0, loop_i = 1'b0;
  logic [1:0] mode_i = 2'd0;
  bit         sel = 1'b0, stall_en = 1'b0, corrupt_en = 1'b0;

  logic [40:0] a_d, b_d;
  logic        a_enq, b_enq, a_deq, b_deq, a_full, b_full, a_empty, b_empty;
  logic        a_busy, a_done, a_error, b_busy, b_done, b_error;
  logic [15:0] a_err_count, a_pass, b_err_count, b_pass;
  logic [23:0] a_err_addr, b_err_addr;
  logic [15:0] a_err_exp, a_err_act, b_err_exp, b_err_act;

  logic        full_m = 1'b0, m_empty = 1'b1;
  logic [15:0] m_q = 16'h0;

  int vectors = 0;
  int miscompares = 0;

  sdram_pattern_tester #(.BASE_ADDR(24'h000000), .NUM_WORDS(16)) dut (
    .clk(clk), .reset_n_i(rst_n), .start_i(start_a), .mode_i(mode_i), .loop_i(loop_i),
    .writer_d_o(a_d), .writer_enq_o(a_enq), .writer_full_i(a_full),
    .reader_q_i(m_q), .reader_deq_o(a_deq), .reader_empty_i(a_empty),
    .busy_o(a_busy), .done_o(a_done), .error_o(a_error), .err_count_o(a_err_count),
    .err_addr_o(a_err_addr), .err_exp_o(a_err_exp), .err_act_o(a_err_act), .pass_count_o(a_pass));

  sdram_pattern_tester #(.BASE_ADDR(24'hFFFFFE), .NUM_WORDS(4)) dut_wrap (
    .clk(clk), .reset_n_i(rst_n), .start_i(start_b), .mode_i(mode_i), .loop_i(loop_i),
    .writer_d_o(b_d), .writer_enq_o(b_enq), .writer_full_i(b_full),
    .reader_q_i(m_q), .reader_deq_o(b_deq), .reader_empty_i(b_empty),
    .busy_o(b_busy), .done_o(b_done), .error_o(b_error), .err_count_o(b_err_count),
    .err_addr_o(b_err_addr), .err_exp_o(b_err_exp), .err_act_o(b_err_act), .pass_count_o(b_pass));

  // ---------------- memory / FIFO model ----------------
  logic        m_enq, m_deq, m_full, cur_busy;
  logic [40:0] m_d;
  assign m_enq    = sel ? b_enq : a_enq;
  assign m_deq    = sel ? b_deq : a_deq;
  assign m_d      = sel ? b_d : a_d;
  assign m_full   = sel ? b_full : a_full;
  assign cur_busy = sel ? b_busy : a_busy;
  assign a_full   = sel ? 1'b1 : full_m;
  assign b_full   = sel ? full_m : 1'b1;
  assign a_empty  = sel ? 1'b1 : m_empty;
  assign b_empty  = sel ? m_empty : 1'b1;

  logic [15:0] mem [logic [23:0]];
  logic [15:0] rd_q[$];
  logic [23:0] wr_log[$];
  int wr_cnt = 0, rd_cnt = 0, ost = 0, max_ost = 0, full_viol = 0, rd_data_bad = 0, done_cnt = 0;

  // Accept commands and dequeues on the clock edge.
  always @(posedge clk or negedge rst_n) begin
    cmd_t c;
    if (!rst_n) begin
      rd_q.delete();
      ost = 0;
    end else begin
      if (m_enq) begin
        c = m_d;
        if (m_full) full_viol++;
        if (c.we) begin
          mem[c.addr] = c.data;
          wr_cnt++;
          wr_log.push_back(c.addr);
        end else begin
          rd_cnt++;
          if (c.data != 16'h0) rd_data_bad++;
          if (corrupt_en && c.addr == 24'h000005) rd_q.push_back(16'hDEAD);
          else if (mem.exists(c.addr)) rd_q.push_back(mem[c.addr]);
          else rd_q.push_back(16'h0);
          ost++;
        end
      end
      if (m_deq) begin
        if (rd_q.size() != 0) void'(rd_q.pop_front());
        ost--;
      end
      if (ost > max_ost) max_ost = ost;
    end
  end

  // Drive FIFO status/data away from the active edge; count done pulses.
  always @(negedge clk) begin
    full_m  = stall_en && ($urandom_range(0, 3) == 0);
    m_empty = (rd_q.size() == 0) || (stall_en && ($urandom_range(0, 2) == 0));
    m_q     = (rd_q.size() != 0) ? rd_q[0] : 16'h0;
    if (a_done || b_done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [1:0] m);
    @(negedge clk);
    mode_i = m;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk); #1;
      if (!cur_busy) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    vectors++; if (a_enq !== 1'b0) begin miscompares++; $display("FAIL reset_enq: got %b want 0", a_enq); end
    vectors++; if (a_d !== 41'h0) begin miscompares++; $display("FAIL reset_cmd: got %h want 0", a_d); end
    vectors++; if (a_deq !== 1'b0) begin miscompares++; $display("FAIL reset_deq: got %b want 0", a_deq); end
    rst_n = 1'b1;
    @(negedge clk); #1;
    vectors++; if (a_pass !== 16'h0) begin miscompares++; $display("FAIL reset_pass: got %h want 0", a_pass); end
    vectors++; if (a_err_count !== 16'h0) begin miscompares++; $display("FAIL reset_errcnt: got %h want 0", a_err_count); end
    vectors++; if ({a_error, a_done, b_busy} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b want 000", {a_error, a_done, b_busy}); end
  endtask

  task automatic test_addr_pattern();
    int bw, br, bd; bit ok;
    sel = 1'b0; bw = wr_cnt; br = rd_cnt; bd = done_cnt;
    pulse_start(2'd0);
    wait_idle(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL addr_timeout: busy never dropped"); end
    vectors++; if (wr_cnt - bw !== 16) begin miscompares++; $display("FAIL addr_writes: got %0d want 16", wr_cnt - bw); end
    vectors++; if (rd_cnt - br !== 16) begin miscompares++; $display("FAIL addr_reads: got %0d want 16", rd_cnt - br); end
    vectors++; if (done_cnt - bd !== 1) begin miscompares++; $display("FAIL addr_done: got %0d want 1", done_cnt - bd); end
    vectors++; if (a_err_count !== 16'h0) begin miscompares++; $display("FAIL addr_errcnt: got %h want 0", a_err_count); end
    vectors++; if (a_pass !== 16'h1) begin miscompares++; $display("FAIL addr_pass: got %h want 1", a_pass); end
    vectors++; if (mem[24'h3] !== 16'h0003) begin miscompares++; $display("FAIL addr_mem3: got %h want 0003", mem[24'h3]); end
    vectors++; if (mem[24'hF] !== 16'h000F) begin miscompares++; $display("FAIL addr_memF: got %h want 000f", mem[24'hF]); end
    vectors++; if (rd_data_bad !== 0) begin miscompares++; $display("FAIL addr_rd_data: got %0d nonzero read data fields want 0", rd_data_bad); end
  endtask

  task automatic test_lfsr_stalls();
    bit ok; int br;
    sel = 1'b0; stall_en = 1'b1; br = rd_cnt;
    pulse_start(2'd2);
    wait_idle(ok);
    stall_en = 1'b0;
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL lfsr_timeout: busy never dropped"); end
    vectors++; if (full_viol !== 0) begin miscompares++; $display("FAIL lfsr_full_enq: got %0d enqueues while full want 0", full_viol); end
    vectors++; if ((max_ost <= 8) !== 1'b1) begin miscompares++; $display("FAIL lfsr_outstanding: got max %0d want <= 8", max_ost); end
    vectors++; if (rd_cnt - br !== 16) begin miscompares++; $display("FAIL lfsr_reads: got %0d want 16", rd_cnt - br); end
    vectors++; if (a_err_count !== 16'h0) begin miscompares++; $display("FAIL lfsr_errcnt: got %h want 0", a_err_count); end
    vectors++; if (mem[24'h0] !== 16'hACE1) begin miscompares++; $display("FAIL lfsr_word0: got %h want ace1", mem[24'h0]); end
    vectors++; if (mem[24'h1] !== 16'h5670) begin miscompares++; $display("FAIL lfsr_word1: got %h want 5670", mem[24'h1]); end
  endtask

  task automatic test_corrupt();
    bit ok;
    sel = 1'b0; corrupt_en = 1'b1;
    pulse_start(2'd0);
    wait_idle(ok);
    corrupt_en = 1'b0;
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL corrupt_timeout: busy never dropped"); end
    vectors++; if (a_err_count !== 16'h1) begin miscompares++; $display("FAIL corrupt_errcnt: got %h want 1", a_err_count); end
    vectors++; if (a_err_addr !== 24'h000005) begin miscompares++; $display("FAIL corrupt_addr: got %h want 000005", a_err_addr); end
    vectors++; if (a_err_exp !== 16'h0005) begin miscompares++; $display("FAIL corrupt_exp: got %h want 0005", a_err_exp); end
    vectors++; if (a_err_act !== 16'hDEAD) begin miscompares++; $display("FAIL corrupt_act: got %h want dead", a_err_act); end
    vectors++; if (a_error !== 1'b1) begin miscompares++; $display("FAIL corrupt_error: got %b want 1", a_error); end
  endtask

  task automatic test_loop();
    bit ok, seen; int bd;
    sel = 1'b0; corrupt_en = 1'b1; loop_i = 1'b1; bd = done_cnt; seen = 1'b0;
    pulse_start(2'd0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (done_cnt - bd >= 3) begin seen = 1'b1; break; end
    end
    loop_i = 1'b0;
    vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL loop_three_passes: got %0d done pulses want 3", done_cnt - bd); end
    wait_idle(ok);
    corrupt_en = 1'b0;
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL loop_timeout: busy never dropped"); end
    vectors++; if ((a_pass == 16'd3 || a_pass == 16'd4) !== 1'b1) begin miscompares++; $display("FAIL loop_pass: got %0d want 3 or 4", a_pass); end
    vectors++; if (a_err_count !== a_pass) begin miscompares++; $display("FAIL loop_errcnt: got %0d want one per pass (%0d)", a_err_count, a_pass); end
    pulse_start(2'd0);
    #1;
    vectors++; if ({a_pass, a_err_count} !== 32'h0) begin miscompares++; $display("FAIL loop_restart_clear: got pass %h errs %h want 0 0", a_pass, a_err_count); end
    vectors++; if ({a_error, a_busy} !== 2'b01) begin miscompares++; $display("FAIL loop_restart_flags: got error,busy %b want 01", {a_error, a_busy}); end
    wait_idle(ok);
    vectors++; if ({ok, a_pass, a_err_count} !== {1'b1, 16'd1, 16'd0}) begin miscompares++; $display("FAIL loop_clean_pass: got ok %b pass %h errs %h want 1 1 0", ok, a_pass, a_err_count); end
  endtask

  task automatic test_reset_mid_read();
    bit ok, seen; int br;
    sel = 1'b0; br = rd_cnt; seen = 1'b0;
    pulse_start(2'd1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (rd_cnt != br) begin seen = 1'b1; break; end
    end
    vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL midrd_reach_read: no read command seen"); end
    rst_n = 1'b0;
    #1;
    vectors++; if (a_busy !== 1'b0) begin miscompares++; $display("FAIL midrd_busy: got %b want 0", a_busy); end
    vectors++; if ({a_enq, a_deq} !== 2'b00) begin miscompares++; $display("FAIL midrd_handshake: got enq,deq %b want 00", {a_enq, a_deq}); end
    vectors++; if (a_d !== 41'h0) begin miscompares++; $display("FAIL midrd_cmd: got %h want 0", a_d); end
    vectors++; if (a_pass !== 16'h0) begin miscompares++; $display("FAIL midrd_pass: got %h want 0", a_pass); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulse_start(2'd1);
    wait_idle(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL midrd_timeout: busy never dropped"); end
    vectors++; if ({a_pass, a_err_count} !== {16'd1, 16'd0}) begin miscompares++; $display("FAIL midrd_clean: got pass %h errs %h want 1 0", a_pass, a_err_count); end
    vectors++; if (mem[24'h3] !== 16'h0008) begin miscompares++; $display("FAIL midrd_walk3: got %h want 0008", mem[24'h3]); end
    vectors++; if (mem[24'hF] !== 16'h8000) begin miscompares++; $display("FAIL midrd_walkF: got %h want 8000", mem[24'hF]); end
  endtask

  task automatic test_addr_wrap();
    bit ok; int n0;
    logic [23:0] exp_a [4];
    exp_a = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
    sel = 1'b1; n0 = wr_log.size();
    pulse_start(2'd3);
    wait_idle(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL wrap_timeout: busy never dropped"); end
    vectors++; if (wr_log.size() - n0 !== 4) begin miscompares++; $display("FAIL wrap_writes: got %0d want 4", wr_log.size() - n0); end
    for (int i = 0; i < 4; i++) begin
      if (n0 + i < wr_log.size()) begin
        vectors++;
        if (wr_log[n0 + i] !== exp_a[i]) begin miscompares++; $display("FAIL wrap_addr%0d: got %h want %h", i, wr_log[n0 + i], exp_a[i]); end
      end
    end
    vectors++; if (mem[24'h000000] !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_data0: got %h want ffff", mem[24'h000000]); end
    vectors++; if (mem[24'hFFFFFE] !== 16'h0001) begin miscompares++; $display("FAIL wrap_dataFE: got %h want 0001", mem[24'hFFFFFE]); end
    vectors++; if ({b_pass, b_err_count, b_error} !== {16'd1, 16'd0, 1'b0}) begin miscompares++; $display("FAIL wrap_status: got pass %h errs %h error %b want 1 0 0", b_pass, b_err_count, b_error); end
    sel = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_addr_pattern();
    test_lfsr_stalls();
    test_corrupt();
    test_loop();
    test_reset_mid_read();
    test_addr_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached after %0d vectors", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
